// File: rtl/sram_fi_pkg.sv
// Shared types and constants for the fault-injectable SRAM model.
package sram_fi_pkg;

    // Fault kinds; encodings match the flt_type port.
    typedef enum logic [1:0] {
        FltSa0  = 2'd0,
        FltSa1  = 2'd1,
        FltTfUp = 2'd2,
        FltTfDn = 2'd3
    } fault_type_e;

    // Table fields are sized for the largest supported memory so the package
    // stays parameter-free; ADDR_W must not exceed 16 and DATA_W not 256.
    localparam int unsigned FLT_ADDR_MAX_W = 16;
    localparam int unsigned FLT_BIT_MAX_W  = 8;

    typedef struct packed {
        logic                      en;
        fault_type_e               ftype;
        logic [FLT_ADDR_MAX_W-1:0] addr;
        logic [FLT_BIT_MAX_W-1:0]  bit_idx;
    } fault_entry_t;

    // Read-during-write modes.
    localparam int unsigned RDW_READ_OLD    = 0;
    localparam int unsigned RDW_WRITE_FIRST = 1;

    typedef enum logic [0:0] {
        StInit,
        StReady
    } state_e;

endpackage

// File: rtl/sram_fault_apply.sv
// Combinational per-word fault overlay. In write mode all four fault kinds
// act on the merged word; in read mode only stuck-at faults are overlaid.
module sram_fault_apply
    import sram_fi_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned NUM_FAULTS = 4
) (
    input  fault_entry_t [NUM_FAULTS-1:0] i_tbl,
    input  logic [ADDR_W-1:0]             i_addr,
    input  logic [DATA_W-1:0]             i_old,
    input  logic [DATA_W-1:0]             i_merged,
    input  logic                          i_wr_mode,
    output logic [DATA_W-1:0]             o_word
);

    logic [DATA_W-1:0] w_hit;
    fault_type_e       w_sel [DATA_W];

    // Per bit, pick the lowest-index enabled entry that targets this word/bit.
    always_comb begin
        w_hit = '0;
        for (int b = 0; b < DATA_W; b++) begin
            w_sel[b] = FltSa0;
        end
        for (int b = 0; b < DATA_W; b++) begin
            for (int f = NUM_FAULTS - 1; f >= 0; f--) begin
                if (i_tbl[f].en &&
                    i_tbl[f].addr == FLT_ADDR_MAX_W'(i_addr) &&
                    i_tbl[f].bit_idx == FLT_BIT_MAX_W'(b)) begin
                    w_hit[b] = 1'b1;
                    w_sel[b] = i_tbl[f].ftype;
                end
            end
        end
    end

    // Apply the selected fault to each bit.
    always_comb begin
        o_word = i_merged;
        for (int b = 0; b < DATA_W; b++) begin
            if (w_hit[b]) begin
                unique case (w_sel[b])
                    FltSa0:  o_word[b] = 1'b0;
                    FltSa1:  o_word[b] = 1'b1;
                    FltTfUp: if (i_wr_mode && !i_old[b] && i_merged[b]) o_word[b] = 1'b0;
                    FltTfDn: if (i_wr_mode && i_old[b] && !i_merged[b]) o_word[b] = 1'b1;
                    default: o_word[b] = i_merged[b];
                endcase
            end
        end
    end

endmodule

// File: rtl/sram_fi.sv
// Single-port synchronous SRAM with bit write mask, power-up init sweep and
// a programmable stuck-at / transition fault table.
module sram_fi
    import sram_fi_pkg::*;
#(
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       ADDR_W     = 6,
    parameter int unsigned       NUM_FAULTS = 4,
    parameter int unsigned       RDW_MODE   = RDW_READ_OLD,
    parameter logic [DATA_W-1:0] INIT_VAL   = '0,
    localparam int unsigned      FLT_IDX_W  = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1,
    localparam int unsigned      BIT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_we,
    input  logic [DATA_W-1:0]    i_we_mask,
    input  logic [ADDR_W-1:0]    i_addr,
    input  logic [DATA_W-1:0]    i_data_in,
    output logic [DATA_W-1:0]    o_data_out,
    output logic                 o_rd_valid,
    output logic                 o_busy,
    input  logic                 i_flt_wr,
    input  logic [FLT_IDX_W-1:0] i_flt_idx,
    input  logic                 i_flt_en,
    input  logic [1:0]           i_flt_type,
    input  logic [ADDR_W-1:0]    i_flt_addr,
    input  logic [BIT_W-1:0]     i_flt_bit
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    state_e                        r_state, w_state_next;
    logic [ADDR_W-1:0]             r_init_ptr, w_init_ptr_next;
    logic [DATA_W-1:0]             r_mem [DEPTH];
    fault_entry_t [NUM_FAULTS-1:0] r_fault_tbl;
    logic [DATA_W-1:0]             r_data_out;
    logic                          r_rd_valid;

    logic                          w_access;
    logic                          w_wr_effective;
    logic                          w_mem_we;
    logic [ADDR_W-1:0]             w_mem_addr;
    logic [DATA_W-1:0]             w_mem_wdata;
    logic [DATA_W-1:0]             w_old;
    logic [DATA_W-1:0]             w_merged;
    logic [DATA_W-1:0]             w_wr_word;
    logic [DATA_W-1:0]             w_rd_src;
    logic [DATA_W-1:0]             w_rd_word;

    assign w_access       = (r_state == StReady) && i_en;
    // An all-zero mask leaves the word untouched, so faults are not re-applied.
    assign w_wr_effective = i_we && (|i_we_mask);
    assign w_old          = r_mem[i_addr];
    assign w_merged       = (w_old & ~i_we_mask) | (i_data_in & i_we_mask);

    sram_fault_apply #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .NUM_FAULTS (NUM_FAULTS)
    ) u_wr_apply (
        .i_tbl      (r_fault_tbl),
        .i_addr     (i_addr),
        .i_old      (w_old),
        .i_merged   (w_merged),
        .i_wr_mode  (1'b1),
        .o_word     (w_wr_word)
    );

    assign w_rd_src = ((RDW_MODE == RDW_WRITE_FIRST) && w_wr_effective) ? w_wr_word : w_old;

    // Stuck-at overlay on the read path catches faults programmed after the write.
    sram_fault_apply #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .NUM_FAULTS (NUM_FAULTS)
    ) u_rd_apply (
        .i_tbl      (r_fault_tbl),
        .i_addr     (i_addr),
        .i_old      (w_rd_src),
        .i_merged   (w_rd_src),
        .i_wr_mode  (1'b0),
        .o_word     (w_rd_word)
    );

    // Next-state logic: init sweep writes INIT_VAL word by word, bypassing faults.
    always_comb begin
        w_state_next    = r_state;
        w_init_ptr_next = r_init_ptr;
        w_mem_we        = 1'b0;
        w_mem_addr      = i_addr;
        w_mem_wdata     = w_wr_word;
        unique case (r_state)
            StInit: begin
                w_mem_we        = 1'b1;
                w_mem_addr      = r_init_ptr;
                w_mem_wdata     = INIT_VAL;
                w_init_ptr_next = r_init_ptr + 1'b1;
                if (r_init_ptr == ADDR_W'(DEPTH - 1)) begin
                    w_state_next = StReady;
                end
            end
            StReady: begin
                w_mem_we = i_en && w_wr_effective;
            end
            default: begin
                w_state_next = StInit;
            end
        endcase
    end

    // State register and init pointer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StInit;
            r_init_ptr <= '0;
        end else begin
            r_state    <= w_state_next;
            r_init_ptr <= w_init_ptr_next;
        end
    end

    // Memory array; not reset, and reset suppresses any write in that cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Registered read data and valid strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_access;
            if (w_access) begin
                r_data_out <= w_rd_word;
            end
        end
    end

    // Fault table programming; out-of-range indices are dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fault_tbl <= '0;
        end else if (i_flt_wr && (32'(i_flt_idx) < NUM_FAULTS)) begin
            r_fault_tbl[i_flt_idx] <= '{
                en:      i_flt_en,
                ftype:   fault_type_e'(i_flt_type),
                addr:    FLT_ADDR_MAX_W'(i_flt_addr),
                bit_idx: FLT_BIT_MAX_W'(i_flt_bit)
            };
        end
    end

    assign o_data_out = r_data_out;
    assign o_rd_valid = r_rd_valid;
    assign o_busy     = (r_state == StInit);

endmodule

// File: tb/tb_sram_fi.sv
// Testbench for sram_fi: read-old and write-first instances driven in lockstep
// and checked against a word-level behavioural model.
module tb_sram_fi;

    logic       clk = 1'b0;
    logic       rst, en, we, flt_wr, flt_en;
    logic [7:0] we_mask, data_in;
    logic [5:0] addr, flt_addr;
    logic [1:0] flt_idx, flt_type;
    logic [2:0] flt_bit;

    logic [7:0] dout0, dout1;
    logic       valid0, valid1, busy0, busy1;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [7:0] m_mem [64];
    bit         m_fen [4];
    logic [1:0] m_ftype [4];
    int         m_faddr [4];
    int         m_fbit [4];
    logic [7:0] m_dout0, m_dout1;
    logic       m_valid;
    bit         m_ready;

    always #5 clk = ~clk;

    sram_fi #(.RDW_MODE(0)) u_dut_old (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_we(we), .i_we_mask(we_mask), .i_addr(addr),
        .i_data_in(data_in), .o_data_out(dout0), .o_rd_valid(valid0), .o_busy(busy0),
        .i_flt_wr(flt_wr), .i_flt_idx(flt_idx), .i_flt_en(flt_en), .i_flt_type(flt_type),
        .i_flt_addr(flt_addr), .i_flt_bit(flt_bit)
    );

    sram_fi #(.RDW_MODE(1)) u_dut_wf (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_we(we), .i_we_mask(we_mask), .i_addr(addr),
        .i_data_in(data_in), .o_data_out(dout1), .o_rd_valid(valid1), .o_busy(busy1),
        .i_flt_wr(flt_wr), .i_flt_idx(flt_idx), .i_flt_en(flt_en), .i_flt_type(flt_type),
        .i_flt_addr(flt_addr), .i_flt_bit(flt_bit)
    );

    // Index of the entry governing bit b of word a, or -1.
    function automatic int owner(int a, int b);
        for (int i = 0; i < 4; i++) begin
            if (m_fen[i] && m_faddr[i] == a && m_fbit[i] == b) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] read_view(int a, logic [7:0] w);
        logic [7:0] r = w;
        for (int b = 0; b < 8; b++) begin
            int k = owner(a, b);
            if (k >= 0 && m_ftype[k] == 2'd0) r[b] = 1'b0;
            if (k >= 0 && m_ftype[k] == 2'd1) r[b] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [7:0] store_view(int a, logic [7:0] old, logic [7:0] mrg);
        logic [7:0] r = mrg;
        for (int b = 0; b < 8; b++) begin
            int k = owner(a, b);
            if (k >= 0) begin
                case (m_ftype[k])
                    2'd0: r[b] = 1'b0;
                    2'd1: r[b] = 1'b1;
                    2'd2: if (old[b] == 1'b0 && mrg[b] == 1'b1) r[b] = 1'b0;
                    default: if (old[b] == 1'b1 && mrg[b] == 1'b0) r[b] = 1'b1;
                endcase
            end
        end
        return r;
    endfunction

    // Predict the effect of the current inputs, then advance one clock.
    task automatic step();
        logic [7:0] old, stored;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_fen[i] = 1'b0;
            m_dout0 = 8'h00;
            m_dout1 = 8'h00;
            m_valid = 1'b0;
            m_ready = 1'b0;
        end else begin
            if (m_ready && en) begin
                old    = m_mem[addr];
                stored = old;
                if (we && we_mask != 8'h00)
                    stored = store_view(int'(addr), old, (old & ~we_mask) | (data_in & we_mask));
                m_dout0    = read_view(int'(addr), old);
                m_dout1    = read_view(int'(addr), stored);
                m_mem[addr] = stored;
                m_valid    = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (flt_wr) begin
                m_fen[flt_idx]   = flt_en;
                m_ftype[flt_idx] = flt_type;
                m_faddr[flt_idx] = int'(flt_addr);
                m_fbit[flt_idx]  = int'(flt_bit);
            end
        end
        @(posedge clk);
        #1;
        flt_wr = 1'b0;
    endtask

    task automatic set_access(input logic e, input logic w, input logic [7:0] m,
                              input logic [5:0] a, input logic [7:0] d);
        en = e; we = w; we_mask = m; addr = a; data_in = d;
    endtask

    task automatic set_fault(input logic [1:0] idx, input logic e, input logic [1:0] t,
                             input logic [5:0] a, input logic [2:0] b);
        flt_wr = 1'b1; flt_idx = idx; flt_en = e; flt_type = t; flt_addr = a; flt_bit = b;
    endtask

    // Clock until busy drops (bounded); returns the number of busy cycles seen.
    task automatic wait_ready(output int n);
        n = 0;
        while (busy0 === 1'b1 && n < 200) begin
            step();
            n++;
        end
        m_ready = 1'b1;
        for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
    endtask

    task automatic test_reset();
        int n;
        set_access(1'b0, 1'b0, 8'h00, 6'd0, 8'h00);
        set_fault(2'd0, 1'b1, 2'd1, 6'd0, 3'd0);  // must be ignored under reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
            failures++; $display("FAIL reset_busy got=%b/%b exp=1", busy0, busy1); end
        checks++; if (valid0 !== 1'b0 || valid1 !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b/%b exp=0", valid0, valid1); end
        checks++; if (dout0 !== 8'h00 || dout1 !== 8'h00) begin
            failures++; $display("FAIL reset_dout got=%h/%h exp=00", dout0, dout1); end
        // restart the sweep mid-way
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready(n);
        checks++; if (n != 64) begin
            failures++; $display("FAIL init_busy_cycles got=%0d exp=64", n); end
        checks++; if (busy1 !== 1'b0) begin
            failures++; $display("FAIL init_busy_wf got=%b exp=0", busy1); end
        set_access(1'b1, 1'b0, 8'h00, 6'd63, 8'h00);
        step();
        checks++; if (valid0 !== 1'b1 || valid1 !== 1'b1) begin
            failures++; $display("FAIL read63_valid got=%b/%b exp=1", valid0, valid1); end
        checks++; if (dout0 !== 8'h00 || dout1 !== 8'h00) begin
            failures++; $display("FAIL read63_data got=%h/%h exp=00", dout0, dout1); end
        set_access(1'b1, 1'b1, 8'hFF, 6'd0, 8'h00);
        step();
        set_access(1'b1, 1'b0, 8'h00, 6'd0, 8'h00);
        step();
        checks++; if (dout0 !== 8'h00) begin
            failures++; $display("FAIL flt_during_rst got=%h exp=00", dout0); end
    endtask

    task automatic test_busy_lockout();
        int n;
        set_access(1'b0, 1'b0, 8'h00, 6'd0, 8'h00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();  // sweep is now past addr 3
        set_access(1'b1, 1'b1, 8'hFF, 6'd3, 8'hAA);
        step();
        checks++; if (valid0 !== 1'b0 || valid1 !== 1'b0) begin
            failures++; $display("FAIL busy_valid got=%b/%b exp=0", valid0, valid1); end
        checks++; if (dout0 !== 8'h00) begin
            failures++; $display("FAIL busy_dout_hold got=%h exp=00", dout0); end
        set_access(1'b0, 1'b0, 8'h00, 6'd0, 8'h00);
        wait_ready(n);
        checks++; if (n != 53) begin
            failures++; $display("FAIL busy_remaining got=%0d exp=53", n); end
        set_access(1'b1, 1'b0, 8'h00, 6'd3, 8'h00);
        step();
        checks++; if (dout0 !== 8'h00 || valid0 !== 1'b1) begin
            failures++; $display("FAIL busy_read3 got=%h/%b exp=00/1", dout0, valid0); end
    endtask

    task automatic test_masked_write();
        set_access(1'b1, 1'b1, 8'hFF, 6'd5, 8'hFF);
        step();
        set_access(1'b1, 1'b1, 8'h0F, 6'd5, 8'h00);
        step();
        checks++; if (dout0 !== 8'hFF) begin
            failures++; $display("FAIL rdw_old got=%h exp=FF", dout0); end
        checks++; if (dout1 !== 8'hF0) begin
            failures++; $display("FAIL rdw_first got=%h exp=F0", dout1); end
        set_access(1'b1, 1'b1, 8'h00, 6'd5, 8'hAA);  // empty mask: read only
        step();
        checks++; if (dout0 !== 8'hF0 || dout1 !== 8'hF0 || valid0 !== 1'b1) begin
            failures++; $display("FAIL zero_mask got=%h/%h/%b exp=F0/F0/1", dout0, dout1, valid0);
        end
        set_access(1'b0, 1'b0, 8'h00, 6'd5, 8'h00);
        step();
        checks++; if (valid0 !== 1'b0 || dout0 !== 8'hF0) begin
            failures++; $display("FAIL idle_hold got=%b/%h exp=0/F0", valid0, dout0); end
        set_access(1'b1, 1'b0, 8'h00, 6'd5, 8'h00);
        step();
        checks++; if (dout0 !== 8'hF0 || dout1 !== 8'hF0) begin
            failures++; $display("FAIL masked_read got=%h/%h exp=F0", dout0, dout1); end
    endtask

    task automatic test_sa1();
        set_access(1'b0, 1'b0, 8'h00, 6'd10, 8'h00);
        set_fault(2'd0, 1'b1, 2'd1, 6'd10, 3'd3);
        step();
        set_access(1'b1, 1'b1, 8'hFF, 6'd10, 8'h00);
        step();
        checks++; if (dout1 !== 8'h08) begin
            failures++; $display("FAIL sa1_write_first got=%h exp=08", dout1); end
        set_access(1'b1, 1'b0, 8'h00, 6'd10, 8'h00);
        step();
        checks++; if (dout0 !== 8'h08) begin
            failures++; $display("FAIL sa1_read got=%h exp=08", dout0); end
        set_access(1'b0, 1'b0, 8'h00, 6'd10, 8'h00);
        set_fault(2'd0, 1'b0, 2'd1, 6'd10, 3'd3);
        step();
        set_access(1'b1, 1'b0, 8'h00, 6'd10, 8'h00);
        step();
        checks++; if (dout0 !== 8'h08) begin
            failures++; $display("FAIL sa1_stored got=%h exp=08", dout0); end
        set_access(1'b1, 1'b1, 8'hFF, 6'd10, 8'h00);
        step();
        set_access(1'b1, 1'b0, 8'h00, 6'd10, 8'h00);
        step();
        checks++; if (dout0 !== 8'h00) begin
            failures++; $display("FAIL sa1_cleared got=%h exp=00", dout0); end
    endtask

    task automatic test_tf_up();
        set_access(1'b0, 1'b0, 8'h00, 6'd20, 8'h00);
        set_fault(2'd1, 1'b1, 2'd2, 6'd20, 3'd0);
        step();
        set_access(1'b1, 1'b1, 8'hFF, 6'd20, 8'h00);
        step();
        set_access(1'b1, 1'b1, 8'hFF, 6'd20, 8'h01);
        step();
        set_access(1'b1, 1'b0, 8'h00, 6'd20, 8'h00);
        step();
        checks++; if (dout0 !== 8'h00 || dout1 !== 8'h00) begin
            failures++; $display("FAIL tf_up_blocked got=%h/%h exp=00", dout0, dout1); end
        set_access(1'b1, 1'b1, 8'hFF, 6'd20, 8'hFE);
        step();
        set_access(1'b1, 1'b0, 8'h00, 6'd20, 8'h00);
        step();
        checks++; if (dout0 !== 8'hFE) begin
            failures++; $display("FAIL tf_up_other_bits got=%h exp=FE", dout0); end
        set_access(1'b1, 1'b1, 8'hFF, 6'd20, 8'h00);
        step();
        // disable in the same cycle as a 0->1 write: old entry still applies
        set_access(1'b1, 1'b1, 8'hFF, 6'd20, 8'h01);
        set_fault(2'd1, 1'b0, 2'd2, 6'd20, 3'd0);
        step();
        checks++; if (dout1 !== 8'h00) begin
            failures++; $display("FAIL tf_same_cycle got=%h exp=00", dout1); end
        set_access(1'b1, 1'b1, 8'hFF, 6'd20, 8'h01);
        step();
        set_access(1'b1, 1'b0, 8'h00, 6'd20, 8'h00);
        step();
        checks++; if (dout0 !== 8'h01) begin
            failures++; $display("FAIL tf_disabled got=%h exp=01", dout0); end
    endtask

    task automatic test_random();
        logic [7:0] m;
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(5) == 0)
                set_fault(2'($urandom_range(3)), 1'($urandom_range(1)), 2'($urandom_range(3)),
                          6'($urandom_range(3)), 3'($urandom_range(7)));
            case ($urandom_range(3))
                0: m = 8'h00;
                1: m = 8'hFF;
                default: m = 8'($urandom);
            endcase
            set_access(1'($urandom_range(3) != 0), 1'($urandom_range(1)), m,
                       ($urandom_range(4) == 0) ? 6'($urandom) : 6'($urandom_range(3)),
                       8'($urandom));
            step();
            checks++; if (valid0 !== m_valid || valid1 !== m_valid) begin
                failures++;
                $display("FAIL rand_valid it=%0d got=%b/%b exp=%b", it, valid0, valid1, m_valid);
            end
            checks++; if (dout0 !== m_dout0) begin
                failures++; $display("FAIL rand_dout_old it=%0d got=%h exp=%h", it, dout0, m_dout0);
            end
            checks++; if (dout1 !== m_dout1) begin
                failures++; $display("FAIL rand_dout_wf it=%0d got=%h exp=%h", it, dout1, m_dout1);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; we = 1'b0; we_mask = 8'h00; addr = 6'd0; data_in = 8'h00;
        flt_wr = 1'b0; flt_idx = 2'd0; flt_en = 1'b0; flt_type = 2'd0;
        flt_addr = 6'd0; flt_bit = 3'd0;
        m_ready = 1'b0; m_valid = 1'b0; m_dout0 = 8'h00; m_dout1 = 8'h00;
        for (int i = 0; i < 4; i++) begin
            m_fen[i] = 1'b0; m_ftype[i] = 2'd0; m_faddr[i] = 0; m_fbit[i] = 0;
        end
        for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
        @(negedge clk);
        test_reset();
        test_busy_lockout();
        test_masked_write();
        test_sa1();
        test_tf_up();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
